uart_tx_arbiter: RTL

- Round-robin arbiter and sequencer that shares one UART byte transmitter between NUM_REQ requesters.
- Each requester streams a frame of bytes over a valid/ready handshake and marks the final byte with req_last.
- The block grants one requester per frame and issues one tx_start pulse per byte. It waits for the transmitter's end_of_byte before the next byte, and inserts a minimum idle gap between frames.
- It aborts a frame if the granted requester stalls mid-frame.

---
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter.
// A requester is granted for a whole frame; each accepted byte produces one
// registered tx_start pulse, and the next byte is taken only after the
// transmitter's end_of_byte rises. Frames are separated by an idle gap, and a
// granted requester that stalls mid-frame has its frame aborted.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int GAP_CYCLES  = 16,
    parameter int STALL_LIMIT = 100000,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           byte_to_send,
    input  logic                 end_of_byte,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [SW-1:0]   stall_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            eob_d;
    logic            last_q;

    logic            eob_rise;
    logic            accept;
    logic [IW-1:0]   grant_next;
    logic [7:0]      data_sel;
    logic [NUM_REQ-1:0] rot;
    logic [IW:0]     pick_sum;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;

    // Only the rising edge of end_of_byte marks a finished byte.
    assign eob_rise   = end_of_byte & ~eob_d;
    assign accept     = (state == S_ISSUE) & req_valid[grant_id];
    assign grant_next = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign data_sel   = 8'(req_data >> {grant_id, 3'b000});
    assign busy       = (state != S_IDLE);

    // Ready goes only to the granted requester, and only while issuing.
    always_comb begin
        req_ready = '0;
        if (state == S_ISSUE)
            req_ready[grant_id] = req_valid[grant_id];
    end

    // Rotate valids so bit k is requester (rr_ptr+k) mod NUM_REQ, then take
    // the lowest set bit and map it back to a requester index.
    always_comb begin
        rot        = (req_valid >> rr_ptr) |
                     (req_valid << ((IW+1)'(NUM_REQ) - {1'b0, rr_ptr}));
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, rr_ptr} + (IW+1)'(k);
            end
        end
        if (pick_sum >= (IW+1)'(NUM_REQ))
            pick_sum = pick_sum - (IW+1)'(NUM_REQ);
        pick_idx = pick_sum[IW-1:0];
    end

    // Frame sequencer with registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            tx_start     <= 1'b0;
            byte_to_send <= 8'h00;
            frame_done   <= 1'b0;
            frame_abort  <= 1'b0;
            stall_cnt    <= '0;
            gap_cnt      <= '0;
            eob_d        <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            eob_d       <= end_of_byte;
            tx_start    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_idx;
                        stall_cnt <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        byte_to_send <= data_sel;
                        last_q       <= req_last[grant_id];
                        tx_start     <= 1'b1;
                        stall_cnt    <= '0;
                        state        <= S_WAIT;
                    end else if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                        frame_abort <= 1'b1;
                        rr_ptr      <= grant_next;
                        stall_cnt   <= '0;
                        gap_cnt     <= '0;
                        state       <= S_GAP;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (eob_rise) begin
                        if (last_q) begin
                            frame_done <= 1'b1;
                            rr_ptr     <= grant_next;
                            gap_cnt    <= '0;
                            state      <= S_GAP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
